// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//   In-order queue of in-flight branch predictions. Each prediction
//   (pc, ghr snapshot, predicted direction) is pushed at the tail. Execute
//   resolves the oldest entry at the head. Every resolution produces a
//   registered predictor-update triple. A wrong prediction additionally
//   raises a mispredict strobe with the corrected history and flushes all
//   younger entries.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   pred_valid/pc/ghr/taken    prediction push request and payload
//   pred_ready                 queue not full
//   res_valid/res_taken        resolve the head entry with its actual direction
//   res_ready                  queue not empty
//   upd_valid/pc/ghr/taken     one-cycle predictor training strobe and triple
//   mispredict, recover_ghr    one-cycle flush strobe and repaired history
//   count                      current occupancy
//   resolved_cnt, mispred_cnt  saturating 16-bit statistics
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 8,
   parameter int GHR_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pred_valid,
   input  logic [PC_W-1:0]          pred_pc,
   input  logic [GHR_W-1:0]         pred_ghr,
   input  logic                     pred_taken,
   output logic                     pred_ready,
   input  logic                     res_valid,
   input  logic                     res_taken,
   output logic                     res_ready,
   output logic                     upd_valid,
   output logic [PC_W-1:0]          upd_pc,
   output logic [GHR_W-1:0]         upd_ghr,
   output logic                     upd_taken,
   output logic                     mispredict,
   output logic [GHR_W-1:0]         recover_ghr,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              resolved_cnt,
   output logic [15:0]              mispred_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PC_W-1:0]  pc_mem  [DEPTH];
   logic [GHR_W-1:0] ghr_mem [DEPTH];
   logic             tkn_mem [DEPTH];

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic             upd_valid_q;
   logic [PC_W-1:0]  upd_pc_q;
   logic [GHR_W-1:0] upd_ghr_q;
   logic             upd_taken_q;
   logic             mispredict_q;
   logic [GHR_W-1:0] recover_ghr_q;
   logic [15:0]      resolved_q, resolved_d;
   logic [15:0]      mispred_q, mispred_d;

   logic push, pop, mis;

   assign pred_ready = (count_q < CW'(DEPTH));
   assign res_ready  = (count_q != '0);

   assign push = pred_valid && pred_ready;
   assign pop  = res_valid && res_ready;
   assign mis  = pop && (res_taken != tkn_mem[head_q]);

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      resolved_d = resolved_q;
      mispred_d  = mispred_q;

      if (mis) begin
         // Flush drops every younger entry and any same-cycle push.
         head_d  = tail_q;
         count_d = '0;
      end else begin
         if (pop) head_d = head_q + 1'b1;
         if (push) tail_d = tail_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end

      if (pop && (resolved_q != '1)) resolved_d = resolved_q + 16'd1;
      if (mis && (mispred_q != '1))  mispred_d  = mispred_q + 16'd1;
   end

   // Entry storage carries no reset; only slots between head and tail are read.
   always_ff @(posedge clk) begin
      if (!reset && push && !mis) begin
         pc_mem[tail_q]  <= pred_pc;
         ghr_mem[tail_q] <= pred_ghr;
         tkn_mem[tail_q] <= pred_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         upd_valid_q   <= 1'b0;
         upd_pc_q      <= '0;
         upd_ghr_q     <= '0;
         upd_taken_q   <= 1'b0;
         mispredict_q  <= 1'b0;
         recover_ghr_q <= '0;
         resolved_q    <= '0;
         mispred_q     <= '0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         upd_valid_q  <= pop;
         mispredict_q <= mis;
         if (pop) begin
            upd_pc_q      <= pc_mem[head_q];
            upd_ghr_q     <= ghr_mem[head_q];
            upd_taken_q   <= res_taken;
            recover_ghr_q <= {ghr_mem[head_q][GHR_W-2:0], res_taken};
         end
         if (pop) resolved_q <= resolved_d;
         if (mis) mispred_q  <= mispred_d;
      end
   end

   assign upd_valid    = upd_valid_q;
   assign upd_pc       = upd_pc_q;
   assign upd_ghr      = upd_ghr_q;
   assign upd_taken    = upd_taken_q;
   assign mispredict   = mispredict_q;
   assign recover_ghr  = recover_ghr_q;
   assign count        = count_q;
   assign resolved_cnt = resolved_q;
   assign mispred_cnt  = mispred_q;

endmodule
